// File: rtl/sisc_ctrl_seq.sv
// SISC control sequencer: fetch/decode/execute/mem/writeback sequencing with
// variable-latency memory handshakes, timeout fault, HALT and retired counter.
module sisc_ctrl_seq #(
   parameter int OPW      = 4,
   parameter int MMW      = 4,
   parameter int STW      = 4,
   parameter int WAIT_MAX = 15,
   parameter int CNTW     = 16
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic [OPW-1:0]  opcode,
   input  logic [MMW-1:0]  mm,
   input  logic [STW-1:0]  stat,
   input  logic            imem_ack,
   input  logic            dmem_ack,
   output logic            pc_rst,
   output logic            pc_write,
   output logic            pc_sel,
   output logic            br_sel,
   output logic            ir_load,
   output logic            imem_req,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic            rf_we,
   output logic            wb_sel,
   output logic [1:0]      alu_op,
   output logic            halted,
   output logic            fault,
   output logic [CNTW-1:0] retired
);

   localparam int WCW = $clog2(WAIT_MAX + 1);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LOD = 4'd1;
   localparam logic [3:0] OP_STR = 4'd2;
   localparam logic [3:0] OP_SWP = 4'd3;
   localparam logic [3:0] OP_BRA = 4'd4;
   localparam logic [3:0] OP_BRR = 4'd5;
   localparam logic [3:0] OP_BNE = 4'd6;
   localparam logic [3:0] OP_BNR = 4'd7;
   localparam logic [3:0] OP_ALU = 4'd8;
   localparam logic [3:0] OP_HLT = 4'd15;
   localparam logic [3:0] AM_IMM = 4'b1000;

   typedef enum logic [2:0] {
      S_START1, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wait_q, wait_d, wait_inc;
   logic [CNTW-1:0] retired_q, retired_d;

   logic [OPW-1:0]  op_hi;
   logic [3:0]      op;
   logic            mask_hit, taken, alu_imm, mem_op, timeout;

   // Any set bit above the low nibble turns the instruction into a NOOP.
   assign op_hi    = opcode >> 4;
   assign op       = (op_hi == '0) ? opcode[3:0] : OP_NOP;
   assign mask_hit = |(stat & mm[STW-1:0]);
   assign alu_imm  = (op == OP_ALU) && (mm == MMW'(AM_IMM));
   assign mem_op   = (op == OP_LOD) || (op == OP_STR) || (op == OP_SWP);
   assign timeout  = (wait_q == WCW'(WAIT_MAX - 1));
   assign wait_inc = (wait_q == WCW'(WAIT_MAX)) ? wait_q : wait_q + 1'b1;

   always_comb begin
      unique case (op)
         OP_BRA, OP_BRR: taken = mask_hit;
         OP_BNE, OP_BNR: taken = !mask_hit;
         default:        taken = 1'b0;
      endcase
   end

   // NOTE: every output and next-state variable gets a default before the case so
   // no path leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      retired_d = retired_q;
      pc_rst    = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 1'b0;
      br_sel    = 1'b0;
      ir_load   = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 1'b0;
      alu_op    = 2'b10;
      halted    = 1'b0;
      fault     = 1'b0;

      unique case (state_q)
         S_START1: begin
            pc_rst  = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            br_sel   = (op == OP_BRA) || (op == OP_BNE);
            pc_sel   = taken;
            pc_write = taken;
            state_d  = (op == OP_HLT) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            alu_op  = alu_imm ? 2'b01 : 2'b00;
            state_d = S_MEM;
         end
         S_MEM: begin
            alu_op = alu_imm ? 2'b11 : 2'b10;
            if (mem_op) begin
               dmem_req = 1'b1;
               dmem_we  = (op == OP_STR) || (op == OP_SWP);
               if (dmem_ack)     state_d = S_WRITEBACK;
               else if (timeout) state_d = S_FAULT;
               else              wait_d  = wait_inc;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            rf_we     = (op == OP_ALU) || (op == OP_LOD) || (op == OP_SWP);
            wb_sel    = (op == OP_LOD) || (op == OP_SWP);
            state_d   = S_FETCH;
            retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: state_d = S_START1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q   <= S_START1;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Self-checking bench for sisc_ctrl_seq: directed corner cases plus random
// instruction streams compared against an instruction-level expectation model.
module tb_sisc_ctrl_seq;

   localparam int WM = 4;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic [3:0]  opcode = '0, mm = '0, stat = '0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0;

   logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_req;
   logic        dmem_req, dmem_we, rf_we, wb_sel, halted, fault;
   logic [1:0]  alu_op;
   logic [15:0] retired;

   logic        s_pc_rst, s_pc_write, s_pc_sel, s_br_sel, s_ir_load, s_imem_req;
   logic        s_dmem_req, s_dmem_we, s_rf_we, s_wb_sel, s_halted, s_fault;
   logic [1:0]  s_alu_op;
   logic [1:0]  s_retired;

   int n_vec = 0, n_fail = 0, exp_ret = 0;

   sisc_ctrl_seq #(.OPW(4), .MMW(4), .STW(4), .WAIT_MAX(WM), .CNTW(16)) u_dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .pc_rst(pc_rst), .pc_write(pc_write),
      .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
      .alu_op(alu_op), .halted(halted), .fault(fault), .retired(retired)
   );

   sisc_ctrl_seq #(.OPW(4), .MMW(4), .STW(4), .WAIT_MAX(WM), .CNTW(2)) u_sat (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .pc_rst(s_pc_rst), .pc_write(s_pc_write),
      .pc_sel(s_pc_sel), .br_sel(s_br_sel), .ir_load(s_ir_load), .imem_req(s_imem_req),
      .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .rf_we(s_rf_we), .wb_sel(s_wb_sel),
      .alu_op(s_alu_op), .halted(s_halted), .fault(s_fault), .retired(s_retired)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] m,
                                         input logic [3:0] s);
      logic hit;
      hit = (s & m) != 4'd0;
      if (op == 4'd4 || op == 4'd5) return hit;
      if (op == 4'd6 || op == 4'd7) return !hit;
      return 1'b0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ret();
      check("retired", 32'(retired), 32'(exp_ret));
      check("retired_sat", 32'(s_retired), (exp_ret > 3) ? 32'd3 : 32'(exp_ret));
   endtask

   task automatic do_reset();
      rst_f = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      exp_ret = 0;
      check("rst_pc_rst", 32'(pc_rst), 32'd1);
      check("rst_alu_op", 32'(alu_op), 32'd2);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_fault_halted", {30'd0, fault, halted}, 32'd0);
      check_ret();
      @(negedge clk);
      rst_f = 1'b1;
      step();
   endtask

   // One instruction starting in FETCH. fw/mw are wait cycles before the ack;
   // a value of WM means the ack never comes and a fault is expected.
   task automatic do_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int fw, input int mw);
      logic tk, imm, is_mem;
      int   n;
      opcode = op; mm = m; stat = s;
      dmem_ack = 1'b0;
      n = (fw < WM) ? fw + 1 : WM;
      for (int i = 0; i < n; i++) begin
         imem_ack = (i == fw);
         @(negedge clk);
         check("fetch_req", 32'(imem_req), 32'd1);
         check("fetch_ir_load", 32'(ir_load), 32'(i == fw));
         check("fetch_pc_write", 32'(pc_write), 32'(i == fw));
         step();
      end
      imem_ack = 1'b0;
      if (fw >= WM) begin
         check("fetch_timeout_fault", 32'(fault), 32'd1);
         return;
      end

      tk = branch_taken(op, m, s);
      @(negedge clk);
      check("dec_pc_write", 32'(pc_write), 32'(tk));
      check("dec_pc_sel", 32'(pc_sel), 32'(tk));
      if (op >= 4'd4 && op <= 4'd7)
         check("dec_br_sel", 32'(br_sel), 32'(op == 4'd4 || op == 4'd6));
      check("dec_no_req", {30'd0, imem_req, ir_load}, 32'd0);
      step();
      if (op == 4'd15) begin
         check("halted", 32'(halted), 32'd1);
         return;
      end

      imm = (op == 4'd8) && (m == 4'd8);
      @(negedge clk);
      check("exe_alu_op", 32'(alu_op), imm ? 32'd1 : 32'd0);
      step();

      is_mem = (op >= 4'd1 && op <= 4'd3);
      n = !is_mem ? 1 : (mw < WM) ? mw + 1 : WM;
      for (int i = 0; i < n; i++) begin
         dmem_ack = is_mem && (i == mw);
         @(negedge clk);
         check("mem_req", 32'(dmem_req), 32'(is_mem));
         check("mem_we", 32'(dmem_we), 32'(op == 4'd2 || op == 4'd3));
         check("mem_alu_op", 32'(alu_op), imm ? 32'd3 : 32'd2);
         step();
      end
      dmem_ack = 1'b0;
      if (is_mem && mw >= WM) begin
         check("mem_timeout_fault", 32'(fault), 32'd1);
         return;
      end

      @(negedge clk);
      check("wb_rf_we", 32'(rf_we), 32'(op == 4'd8 || op == 4'd1 || op == 4'd3));
      check("wb_wb_sel", 32'(wb_sel), 32'(op == 4'd1 || op == 4'd3));
      check("wb_no_dmem", 32'(dmem_req), 32'd0);
      step();
      exp_ret++;
      check_ret();
   endtask

   task automatic rand_instr();
      logic [3:0] op, m;
      op = 4'($urandom_range(0, 14));
      m  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      do_instr(op, m, 4'($urandom_range(0, 15)), $urandom_range(0, WM - 1),
               $urandom_range(0, WM - 1));
   endtask

   task automatic check_sticky(input string tag, input logic flt, input logic hlt);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check(tag, {29'd0, imem_req, fault, halted}, {29'd0, 1'b0, flt, hlt});
      end
      step();
   endtask

   initial begin
      #2;
      do_reset();

      do_instr(4'd0, 4'd0, 4'd0, 3, 0);            // fetch held off for three cycles
      do_instr(4'd6, 4'b0100, 4'b0000, 0, 0);      // BNE taken
      do_instr(4'd6, 4'b0100, 4'b0100, 0, 0);      // BNE not taken
      do_instr(4'd4, 4'b0011, 4'b0010, 1, 0);      // BRA taken
      do_instr(4'd8, 4'd8, 4'd0, 0, 0);            // ALU immediate
      do_instr(4'd1, 4'd0, 4'd0, 0, WM - 1);       // ack on last allowed cycle
      do_instr(4'd3, 4'd0, 4'd0, WM - 1, WM - 1);

      for (int k = 0; k < 40; k++) rand_instr();

      // Asynchronous reset while a load is waiting on the data memory.
      opcode = 4'd1;
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      step();
      step();
      step();
      @(negedge clk);
      check("midmem_req", 32'(dmem_req), 32'd1);
      #2;
      do_reset();

      do_instr(4'd0, 4'd0, 4'd0, WM, 0);           // fetch timeout
      check_sticky("fetch_fault_sticky", 1'b1, 1'b0);
      do_reset();

      do_instr(4'd2, 4'd0, 4'd0, 0, WM);           // store timeout
      check_sticky("mem_fault_sticky", 1'b1, 1'b0);
      do_reset();

      for (int k = 0; k < 3; k++) rand_instr();
      do_instr(4'd15, 4'd0, 4'd0, 1, 0);
      check_ret();
      check_sticky("halt_sticky", 1'b0, 1'b1);
      check_ret();
      do_reset();

      for (int k = 0; k < 5; k++) rand_instr();
      check_ret();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
